// File: rtl/endian_serializer.sv
// Word-to-bit serializer with per-word MSB/LSB-first order over valid/ready.
// Build option ENDIAN_SER_PARITY_EN appends an even-parity bit to each word.
module endian_serializer #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         s_valid,
    output logic         s_ready,
    input  logic [N-1:0] s_data,
    input  logic         rvs_en,
    output logic         m_valid,
    input  logic         m_ready,
    output logic         m_bit,
    output logic         m_last,
    output logic         busy
);

    localparam int CW = $clog2(N + 1);
`ifdef ENDIAN_SER_PARITY_EN
    localparam int LASTIDX = N;
`else
    localparam int LASTIDX = N - 1;
`endif
    localparam logic [CW-1:0] LAST_CNT = CW'(LASTIDX);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [N-1:0]  sh;
    logic [N-1:0]  sh_nxt;
    logic [N-1:0]  rev;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nxt;
    logic          in_shift;
    logic          at_last;
    logic          xfer;
    logic          accept;
    logic          data_bit;

    always_comb begin
        rev = '0;
        for (int k = 0; k < N; k++) begin
            rev[N-1-k] = s_data[k];
        end
    end

    assign in_shift = (state == SHIFT);
    assign at_last  = in_shift && (cnt == LAST_CNT);
    assign xfer     = in_shift && m_ready;
    // s_ready sees m_ready combinationally so back-to-back words have no bubble
    assign s_ready  = !rst && ((state == IDLE) || (xfer && at_last));
    assign accept   = s_valid && s_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                if (xfer && at_last) begin
                    state_nxt = accept ? SHIFT : IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        sh_nxt  = sh;
        cnt_nxt = cnt;
        if (accept) begin
            sh_nxt  = rvs_en ? rev : s_data;
            cnt_nxt = '0;
        end else if (xfer && !at_last) begin
            sh_nxt  = {sh[N-2:0], 1'b0};
            cnt_nxt = cnt + 1'b1;
        end else if (xfer) begin
            sh_nxt  = '0;
            cnt_nxt = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sh  <= '0;
            cnt <= '0;
        end else begin
            sh  <= sh_nxt;
            cnt <= cnt_nxt;
        end
    end

`ifdef ENDIAN_SER_PARITY_EN
    logic par;

    // Parity covers the word as presented, so it does not depend on rvs_en
    always_ff @(posedge clk) begin
        if (rst) begin
            par <= 1'b0;
        end else if (accept) begin
            par <= ^s_data;
        end
    end

    assign data_bit = at_last ? par : sh[N-1];
`else
    assign data_bit = sh[N-1];
`endif

    always_comb begin
        m_valid = 1'b0;
        busy    = 1'b0;
        m_bit   = 1'b0;
        m_last  = 1'b0;
        if (in_shift) begin
            m_valid = 1'b1;
            busy    = 1'b1;
            m_bit   = data_bit;
            m_last  = at_last;
        end
    end

endmodule

// File: tb/tb_endian_serializer.sv
// Scoreboard bench for endian_serializer: directed cases plus random traffic.
// Expected bit streams come from a word-level model pushed at each accept.
module tb_endian_serializer;

    localparam int N = 4;
`ifdef ENDIAN_SER_PARITY_EN
    localparam int WT = N + 1;
`else
    localparam int WT = N;
`endif

    typedef struct {
        logic b;
        logic l;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         s_valid;
    logic         s_ready;
    logic [N-1:0] s_data;
    logic         rvs_en;
    logic         m_valid;
    logic         m_ready;
    logic         m_bit;
    logic         m_last;
    logic         busy;

    int   errors = 0;
    int   checks = 0;
    exp_t q[$];
    logic hold_pend = 1'b0;
    logic hold_b;
    logic hold_l;

    endian_serializer #(.N(N)) dut (
        .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready),
        .s_data(s_data), .rvs_en(rvs_en), .m_valid(m_valid),
        .m_ready(m_ready), .m_bit(m_bit), .m_last(m_last), .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    // Reference: the word's bits in send order, then optional parity
    function automatic void model_push(logic [N-1:0] d, logic r);
        exp_t e;
        for (int k = 0; k < N; k++) begin
            e.b = r ? d[k] : d[N-1-k];
            e.l = (k == WT - 1);
            q.push_back(e);
        end
`ifdef ENDIAN_SER_PARITY_EN
        e.b = ^d;
        e.l = 1'b1;
        q.push_back(e);
`endif
    endfunction

    always @(negedge clk) begin
        exp_t e;
        if (!rst && hold_pend) begin
            check("stall_valid", 32'(m_valid), 32'd1);
            check("stall_bit", 32'(m_bit), 32'(hold_b));
            check("stall_last", 32'(m_last), 32'(hold_l));
        end
        hold_pend = !rst && m_valid && !m_ready;
        hold_b    = m_bit;
        hold_l    = m_last;
        if (!rst && m_valid && m_ready) begin
            if (q.size() == 0) begin
                check("unexpected_bit", 32'(m_valid), 32'd0);
            end else begin
                e = q.pop_front();
                check("m_bit", 32'(m_bit), 32'(e.b));
                check("m_last", 32'(m_last), 32'(e.l));
            end
        end
    end

    // Starts and ends just after a rising edge; leaves s_valid high
    task automatic issue(input logic [N-1:0] d, input logic r, output int waited);
        logic acc;
        s_valid = 1'b1;
        s_data  = d;
        rvs_en  = r;
        waited  = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            acc = s_ready;
            waited++;
            @(posedge clk);
            #1;
            if (acc) begin
                model_push(d, r);
                return;
            end
        end
        check("accept_timeout", 32'd0, 32'd1);
    endtask

    task automatic drain(input int n);
        m_ready = 1'b1;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            check("valid_run", 32'(m_valid), 32'd1);
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        check("end_valid", 32'(m_valid), 32'd0);
        check("end_ready", 32'(s_ready), 32'd1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int w;
        logic acc;
        logic [N-1:0] pd;
        logic pr;
        rst     = 1'b1;
        s_valid = 1'b0;
        s_data  = '0;
        rvs_en  = 1'b0;
        m_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        check("rst_m_valid", 32'(m_valid), 32'd0);
        check("rst_m_bit", 32'(m_bit), 32'd0);
        check("rst_m_last", 32'(m_last), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_s_ready", 32'(s_ready), 32'd0);
        @(posedge clk);
        #1;
        rst     = 1'b0;
        m_ready = 1'b1;
        @(negedge clk);
        check("idle_s_ready", 32'(s_ready), 32'd1);
        @(posedge clk);
        #1;

        // MSB-first, then LSB-first of the same word
        issue(4'b1011, 1'b0, w);
        s_valid = 1'b0;
        @(negedge clk);
        check("latency_valid", 32'(m_valid), 32'd1);
        check("latency_busy", 32'(busy), 32'd1);
        @(posedge clk);
        #1;
        drain(WT - 1);
        issue(4'b1011, 1'b1, w);
        s_valid = 1'b0;
        drain(WT);

        // Back-to-back words with no bubble
        issue(4'hA, 1'b0, w);
        issue(4'h3, 1'b0, w);
        check("b2b_accept_cycle", 32'(w), 32'(WT));
        s_valid = 1'b0;
        drain(WT);

        // Stall after the second bit
        issue(4'b0110, 1'b0, w);
        s_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        m_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("hold_bit", 32'(m_bit), 32'd1);
            check("hold_last", 32'(m_last), 32'd0);
            @(posedge clk);
            #1;
        end
        drain(WT - 2);

        // Reset mid-word discards it
        issue(4'hF, 1'b0, w);
        repeat (2) @(posedge clk);
        #1;
        rst     = 1'b1;
        m_ready = 1'b0;
        @(negedge clk);
        check("rst_blocks_accept", 32'(s_ready), 32'd0);
        @(posedge clk);
        #1;
        rst     = 1'b0;
        s_valid = 1'b0;
        q.delete();
        m_ready = 1'b1;
        @(negedge clk);
        check("post_rst_valid", 32'(m_valid), 32'd0);
        check("post_rst_busy", 32'(busy), 32'd0);
        @(posedge clk);
        #1;
        issue(4'h8, 1'b0, w);
        s_valid = 1'b0;
        drain(WT);

        issue(4'b1001, 1'b0, w);
        s_valid = 1'b0;
        drain(WT);

        // Random traffic with random backpressure and junk inputs when idle
        for (int i = 0; i < 1500; i++) begin
            m_ready = ($urandom_range(0, 3) != 0);
            if (!s_valid) begin
                s_data = N'($urandom);
                rvs_en = 1'($urandom);
                if ($urandom_range(0, 2) == 0) s_valid = 1'b1;
            end
            pd = s_data;
            pr = rvs_en;
            @(negedge clk);
            acc = s_valid && s_ready;
            @(posedge clk);
            #1;
            if (acc) begin
                model_push(pd, pr);
                s_valid = ($urandom_range(0, 1) == 0);
                s_data  = N'($urandom);
                rvs_en  = 1'($urandom);
            end
        end

        s_valid = 1'b0;
        m_ready = 1'b1;
        for (int i = 0; i < 200; i++) begin
            if (q.size() == 0 && !m_valid) break;
            @(posedge clk);
            #1;
        end
        check("queue_drained", 32'(q.size()), 32'd0);
        check("final_idle", 32'(m_valid), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
